// File: rtl/reg_file_wb_if.sv
// ---------------------------------------------------------------------------
// reg_file_wb_if
// Purpose : bundles the write-back and read-port signals of the register
//           file so the data-select stage / decode stage (master) and the
//           register file (slave) connect through a single port.
// Signals :
//   wr_en      - write-back enable
//   wr_addr    - destination register index
//   wr_data    - write-back value
//   rd_en      - read request covering both read ports
//   rd_addr_a  - read port A index
//   rd_addr_b  - read port B index
//   rd_data_a  - registered read result A
//   rd_data_b  - registered read result B
//   rd_valid   - one-cycle pulse per accepted read
// ---------------------------------------------------------------------------
interface reg_file_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
// Purpose : 2**ADDR_W x DATA_W register file with one write-back port and
//           two registered read ports. Register 0 is hard-wired to zero.
//           Reads have one cycle of latency and forward a same-edge write.
// Ports   :
//   clk    - single clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset; clears every register, both read
//            results and rd_valid, and overrides any write/read at that edge
//   bus    - reg_file_wb_if slave modport (write-back + dual read port)
// ---------------------------------------------------------------------------
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_wb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_rd_valid;

  logic              w_wr_live;
  logic [DATA_W-1:0] w_read_a;
  logic [DATA_W-1:0] w_read_b;

  // A write to index 0 is dropped entirely, so it must never be forwarded.
  assign w_wr_live = bus.wr_en && (bus.wr_addr != '0);

  // Read value for each port: zero for index 0, the incoming write data when
  // the same edge writes that index, otherwise the stored contents.
  always_comb begin
    w_read_a = r_regs[bus.rd_addr_a];
    if (bus.rd_addr_a == '0) begin
      w_read_a = '0;
    end else if (w_wr_live && (bus.wr_addr == bus.rd_addr_a)) begin
      w_read_a = bus.wr_data;
    end
  end

  always_comb begin
    w_read_b = r_regs[bus.rd_addr_b];
    if (bus.rd_addr_b == '0) begin
      w_read_b = '0;
    end else if (w_wr_live && (bus.wr_addr == bus.rd_addr_b)) begin
      w_read_b = bus.wr_data;
    end
  end

  // Storage plus read registers. Reset wins over a simultaneous write or
  // read, so a pending read result is discarded and the write is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_wr_live) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data_a <= w_read_a;
        r_rd_data_b <= w_read_b;
      end
    end
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  assign bus.rd_data_a = r_rd_data_a;
  assign bus.rd_data_b = r_rd_data_b;
  assign bus.rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wb
// Purpose : self-checking bench for reg_file_wb. A table of per-cycle
//           vectors (inputs + expected registered outputs after the edge)
//           covers reset, forwarding, address-0 handling and hold behaviour;
//           hand-written sequences cover mid-stream reset and a full sweep.
// ---------------------------------------------------------------------------
module tb_reg_file_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    logic              exp_valid;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  vec_t vecs[$];

  reg_file_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rs, input logic we, input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd, input logic re,
    input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
    input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
    input logic ev);
    vec_t v;
    v.rst_n = rs; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr_a = ra; v.rd_addr_b = rb;
    v.exp_a = ea; v.exp_b = eb; v.exp_valid = ev;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return 32'h5A00_0000 + DATA_W'(i * 32'h0001_0101);
  endfunction

  // Drive one cycle of inputs on the falling edge, then let the rising edge
  // take them; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rs, input logic we,
                               input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic re,
                               input logic [ADDR_W-1:0] ra,
                               input logic [ADDR_W-1:0] rb);
    @(negedge clk);
    rst_n         = rs;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_en     = re;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] ea,
                             input logic [DATA_W-1:0] eb, input logic ev);
    checkOne({tag, " rd_data_a"}, bus.rd_data_a, ea);
    checkOne({tag, " rd_data_b"}, bus.rd_data_b, eb);
    checkOne({tag, " rd_valid"}, DATA_W'(bus.rd_valid), DATA_W'(ev));
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;

    //             rst we wa  wr_data       re ra  rb  exp_a         exp_b         ev
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 3,  7,  32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 1, 5, 32'hAAAAAAAA, 0, 0,  0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 5,  5,  32'hAAAAAAAA, 32'hAAAAAAAA, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 5,  5,  32'hAAAAAAAA, 32'hAAAAAAAA, 0));
    vecs.push_back(mk(1, 1, 9, 32'hBBBBBBBB, 1, 9,  0,  32'hBBBBBBBB, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 3,  9,  32'h0,        32'hBBBBBBBB, 1));
    vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 0, 0,  0,  32'h0,        32'hBBBBBBBB, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0,  5,  32'h0,        32'hAAAAAAAA, 1));
    vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 1, 0,  0,  32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 1, 4, 32'h12345678, 0, 0,  0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 4, 32'h00000001, 1, 4,  4,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 4,  5,  32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 1, 5, 32'hAAAAAAAA, 0, 0,  0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 5,  31, 32'hAAAAAAAA, 32'h0,        1));
    vecs.push_back(mk(1, 1, 5, 32'h0,        0, 5,  5,  32'hAAAAAAAA, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 5,  5,  32'hAAAAAAAA, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 5,  5,  32'hAAAAAAAA, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 5,  5,  32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 1, 31, 32'hDEADBEEF, 1, 30, 31, 32'h0,       32'hDEADBEEF, 1));
    vecs.push_back(mk(1, 1, 7, 32'h11111111, 0, 0,  0,  32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 1, 7, 32'h22222222, 1, 7,  7,  32'h22222222, 32'h22222222, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 7,  31, 32'h22222222, 32'hDEADBEEF, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 31, 7,  32'hDEADBEEF, 32'h22222222, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].wr_en, vecs[i].wr_addr,
                    vecs[i].wr_data, vecs[i].rd_en, vecs[i].rd_addr_a,
                    vecs[i].rd_addr_b);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                  vecs[i].exp_valid);
    end

    // Reset in the middle of a continuous read stream: the pending result
    // is dropped, reg31 is cleared, and reads resume on the next edge.
    applyStimulus(1, 0, 0, 32'h0, 1, 31, 7);
    checkOutput("midrst pre", 32'hDEADBEEF, 32'h22222222, 1'b1);
    applyStimulus(0, 1, 31, 32'hCAFEF00D, 1, 31, 7);
    checkOutput("midrst during", 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 0, 0, 32'h0, 1, 31, 7);
    checkOutput("midrst after", 32'h0, 32'h0, 1'b1);

    // Sweep: fill every writable register, then read mirrored index pairs
    // back-to-back so rd_valid stays high throughout.
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      applyStimulus(1, 1, ADDR_W'(i), pattern(i), 0, 0, 0);
    end
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      logic [DATA_W-1:0] ea;
      logic [DATA_W-1:0] eb;
      int j;
      j  = (1 << ADDR_W) - 1 - i;
      ea = (i == 0) ? '0 : pattern(i);
      eb = (j == 0) ? '0 : pattern(j);
      applyStimulus(1, 0, 0, 32'h0, 1, ADDR_W'(i), ADDR_W'(j));
      checkOutput($sformatf("sweep%0d", i), ea, eb, 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
